// File: rtl/spm_mul_pkg.sv
// Shared types and defaults for the SPM shift-add multiplier core.
package spm_mul_pkg;

    localparam int SPM_MUL_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } spm_mul_state_t;

endpackage

// File: rtl/spm_mul_core.sv
// Sequential shift-add unsigned multiplier, one multiplier bit per clock.
// Optional early termination on an exhausted multiplier: SPM_MUL_EARLY_TERM_EN.
//
//   state | meaning
//   IDLE  | no product since reset, waiting for start
//   BUSY  | accumulating partial products
//   DONE  | product valid on p, held until next start
module spm_mul_core
    import spm_mul_pkg::*;
#(
    parameter int WIDTH = SPM_MUL_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     mc,
    input  logic [WIDTH-1:0]     mp,
    output logic [2*WIDTH-1:0]   p,
    output logic                 done,
    output logic                 busy
);

    localparam int              CW       = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]   LAST_CNT = CW'(WIDTH - 1);

    spm_mul_state_t         r_state;
    spm_mul_state_t         w_next;
    logic [2*WIDTH-1:0]     r_mcand;
    logic [2*WIDTH-1:0]     r_acc;
    logic [WIDTH-1:0]       r_mp_sr;
    logic [CW-1:0]          r_cnt;
    logic [WIDTH-1:0]       w_mp_nxt;
    logic                   w_last;
    logic                   w_accept;

    assign w_mp_nxt = r_mp_sr >> 1;
    assign w_accept = start && (r_state != BUSY);

`ifdef SPM_MUL_EARLY_TERM_EN
    // Nothing left to add once the remaining multiplier bits are all zero.
    assign w_last = (r_cnt == LAST_CNT) || (w_mp_nxt == '0);
`else
    assign w_last = (r_cnt == LAST_CNT);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (start)  w_next = BUSY;
            BUSY:    if (w_last) w_next = DONE;
            DONE:    if (start)  w_next = BUSY;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        unique case (r_state)
            BUSY:    busy = 1'b1;
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mcand <= '0;
            r_acc   <= '0;
            r_mp_sr <= '0;
            r_cnt   <= '0;
        end else if (w_accept) begin
            r_mcand <= {{WIDTH{1'b0}}, mc};
            r_acc   <= '0;
            r_mp_sr <= mp;
            r_cnt   <= '0;
        end else if (r_state == BUSY) begin
            if (r_mp_sr[0]) begin
                r_acc <= r_acc + r_mcand;
            end
            r_mcand <= r_mcand << 1;
            r_mp_sr <= w_mp_nxt;
            r_cnt   <= r_cnt + CW'(1);
        end
    end

    // Product is the accumulator itself, so p has no path from the inputs.
    assign p = r_acc;

endmodule

// File: tb/tb_spm_mul_core.sv
// Scoreboard bench for spm_mul_core: expected products and latencies queued at start.
module tb_spm_mul_core;

    localparam int W = 32;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic [W-1:0]    mc = '0;
    logic [W-1:0]    mp = '0;
    logic [2*W-1:0]  p;
    logic            done;
    logic            busy;

    int n_vec = 0;
    int n_err = 0;

    logic [2*W-1:0]  q_prod[$];
    int              q_lat[$];

    spm_mul_core #(.WIDTH(W)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .mc    (mc),
        .mp    (mp),
        .p     (p),
        .done  (done),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int exp_latency(input logic [W-1:0] b);
        int lat;
        lat = W;
`ifdef SPM_MUL_EARLY_TERM_EN
        lat = 1;
        for (int i = 0; i < W; i++) if (b[i]) lat = i + 1;
`endif
        return lat;
    endfunction

    // One operation: start at E0, optional scrambling of operands while busy,
    // optional ignored second start issued so it is sampled at E0+restart_k+1.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input int restart_k, input bit scramble);
        int k;
        int lat;
        logic [2*W-1:0] ep;
        @(negedge clk);
        start = 1'b1; mc = a; mp = b;
        q_prod.push_back({{W{1'b0}}, a} * {{W{1'b0}}, b});
        q_lat.push_back(exp_latency(b));
        @(negedge clk);
        start = 1'b0;
        chk("busy_at_e0", {63'd0, busy}, 64'd1);
        chk("done_low_e0", {63'd0, done}, 64'd0);
        chk("p_clear_e0", p, 64'd0);
        for (k = 1; k <= 200; k++) begin
            @(negedge clk);
            if (done) break;
            start = (k == restart_k);
            if (k == restart_k) begin
                mc = ~a; mp = b ^ 32'h5A5A_0F0F;
            end else if (scramble) begin
                mc = $urandom; mp = $urandom;
            end
        end
        start = 1'b0;
        chk("done_timeout", {63'd0, done}, 64'd1);
        lat = q_lat.pop_front();
        ep  = q_prod.pop_front();
        chk("latency", 64'(k), 64'(lat));
        chk("product", p, ep);
        chk("busy_low_done", {63'd0, busy}, 64'd0);
    endtask

    initial begin
        // Reset then idle
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_p", p, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        repeat (5) @(negedge clk);
        chk("idle_busy", {63'd0, busy}, 64'd0);
        chk("idle_done", {63'd0, done}, 64'd0);

        // Basic product and done hold
        run_op(32'h7, 32'h6, 0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("hold_done", {63'd0, done}, 64'd1);
            chk("hold_p", p, 64'h2A);
        end

        // Full range, back-to-back from DONE
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0);
        chk("full_range_const", p, 64'hFFFF_FFFE_0000_0001);

        // Start while busy is ignored
        run_op(32'h0000_1234, 32'h8000_0003, 4, 1'b0);

        // Random operands, some scrambled mid-busy
        for (int i = 0; i < 8; i++) begin
            run_op($urandom, $urandom, 0, i[0]);
        end

        // Reset mid-operation
        @(negedge clk);
        start = 1'b1; mc = 32'hDEAD; mp = 32'hBEEF;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_busy", {63'd0, busy}, 64'd0);
        chk("abort_done", {63'd0, done}, 64'd0);
        chk("abort_p", p, 64'd0);
        // start while in reset is lost
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0; rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_abort_busy", {63'd0, busy}, 64'd0);
        chk("post_abort_done", {63'd0, done}, 64'd0);
        run_op(32'd3, 32'd5, 0, 1'b0);
        chk("three_by_five", p, 64'd15);

`ifdef SPM_MUL_EARLY_TERM_EN
        run_op(32'h10, 32'h0, 0, 1'b0);
        run_op(32'h10, 32'h5, 0, 1'b0);
        chk("et_0x50", p, 64'h50);
        run_op(32'h3, 32'h8000_0000, 0, 1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
